wb_port_arbiter: RTL and testbench

Write-back arbiter for the 8x16 register file. Shares its single write port between the ALU result path and the memory-load result path. Each source gets a one-entry holding buffer with a valid/ready handshake. Grants are round-robin, with age ordering for same-register writes, and the block drives the register-file write controls from registers. A pending-write mask lets decode detect in-flight destinations.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_hold_slot.sv | 39 +++
 rtl/wb_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter slice.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_ADDR_W = 3;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Field widths follow the package defaults above.
  typedef struct packed {
    logic                 v;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } hold_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding buffer with valid/ready handshake; refills on the
// same edge its entry is granted.
module wb_hold_slot
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WB_ADDR_W-1:0] addr_i,
  input  logic [WB_DATA_W-1:0] data_i,
  input  logic                 grant_i,
  output logic                 accept_o,
  output hold_t                entry_o
);

  hold_t entry_q, entry_d;

  always_comb begin
    ready_o  = reset & (~entry_q.v | grant_i);
    accept_o = valid_i & ready_o;
    entry_d  = entry_q;
    if (accept_o) begin
      entry_d.v    = 1'b1;
      entry_d.addr = addr_i;
      entry_d.data = data_i;
    end else if (grant_i) begin
      entry_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: ALU and MEM holding slots share one registered
// register-file write port. Optional forwarding ports under WB_FWD_EN.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   write_back,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [DATA_W-1:0]      write_data,
  output logic [(2**ADDR_W)-1:0] pend_mask
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]      fwd_addr0,
  input  logic [ADDR_W-1:0]      fwd_addr1,
  output logic                   fwd_hit0,
  output logic                   fwd_hit1,
  output logic [DATA_W-1:0]      fwd_data0,
  output logic [DATA_W-1:0]      fwd_data1
`endif
);

  hold_t             alu_h, mem_h;
  logic              alu_acc, mem_acc;
  logic              alu_gnt, mem_gnt;
  logic              sel;
  logic              rr_last_q, rr_last_d;
  logic              older_q, older_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  wb_hold_slot u_alu_slot (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (alu_valid),
    .ready_o  (alu_ready),
    .addr_i   (alu_addr),
    .data_i   (alu_data),
    .grant_i  (alu_gnt),
    .accept_o (alu_acc),
    .entry_o  (alu_h)
  );

  wb_hold_slot u_mem_slot (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (mem_valid),
    .ready_o  (mem_ready),
    .addr_i   (mem_addr),
    .data_i   (mem_data),
    .grant_i  (mem_gnt),
    .accept_o (mem_acc),
    .entry_o  (mem_h)
  );

  // Same-register pairs go by age so program order survives; otherwise round-robin.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    sel     = SRC_ALU;
    if (reset) begin
      if (alu_h.v && mem_h.v) begin
        sel     = (alu_h.addr == mem_h.addr) ? older_q : ~rr_last_q;
        mem_gnt = (sel == SRC_MEM);
        alu_gnt = (sel == SRC_ALU);
      end else begin
        alu_gnt = alu_h.v;
        mem_gnt = mem_h.v;
      end
    end
  end

  always_comb begin
    older_d = older_q;
    if (alu_acc && mem_acc)                  older_d = SRC_MEM;
    else if (alu_acc && mem_h.v && !mem_gnt) older_d = SRC_MEM;
    else if (mem_acc && alu_h.v && !alu_gnt) older_d = SRC_ALU;

    rr_last_d = rr_last_q;
    if (alu_gnt) rr_last_d = SRC_ALU;
    if (mem_gnt) rr_last_d = SRC_MEM;

    wb_d    = alu_gnt | mem_gnt;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (mem_gnt) begin
      waddr_d = mem_h.addr;
      wdata_d = mem_h.data;
    end else if (alu_gnt) begin
      waddr_d = alu_h.addr;
      wdata_d = alu_h.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_last_q <= SRC_ALU;
      older_q   <= SRC_ALU;
      wb_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      older_q   <= older_d;
      wb_q      <= wb_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign write_back = wb_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;

  always_comb begin
    pend_mask = '0;
    if (reset) begin
      if (alu_h.v) pend_mask[alu_h.addr] = 1'b1;
      if (mem_h.v) pend_mask[mem_h.addr] = 1'b1;
      if (wb_q)    pend_mask[waddr_q]    = 1'b1;
    end
  end

`ifdef WB_FWD_EN
  function automatic logic [DATA_W:0] fwd_pick(
    input hold_t             yng,
    input hold_t             old,
    input logic              wb,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [ADDR_W-1:0] a
  );
    if (yng.v && yng.addr == a) return {1'b1, yng.data};
    if (old.v && old.addr == a) return {1'b1, old.data};
    if (wb && wa == a)          return {1'b1, wd};
    return '0;
  endfunction

  hold_t fwd_yng, fwd_old;

  always_comb begin
    fwd_yng = (older_q == SRC_MEM) ? alu_h : mem_h;
    fwd_old = (older_q == SRC_MEM) ? mem_h : alu_h;
    {fwd_hit0, fwd_data0} = fwd_pick(fwd_yng, fwd_old, wb_q, waddr_q, wdata_q, fwd_addr0);
    {fwd_hit1, fwd_data1} = fwd_pick(fwd_yng, fwd_old, wb_q, waddr_q, wdata_q, fwd_addr1);
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; forwarding checks under WB_FWD_EN.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;
  logic        write_back;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [7:0]  pend_mask;
`ifdef WB_FWD_EN
  logic [2:0]  fwd_addr0, fwd_addr1;
  logic        fwd_hit0, fwd_hit1;
  logic [15:0] fwd_data0, fwd_data1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .write_back (write_back),
    .write_addr (write_addr),
    .write_data (write_data),
    .pend_mask  (pend_mask)
`ifdef WB_FWD_EN
    ,
    .fwd_addr0  (fwd_addr0),
    .fwd_addr1  (fwd_addr1),
    .fwd_hit0   (fwd_hit0),
    .fwd_hit1   (fwd_hit1),
    .fwd_data0  (fwd_data0),
    .fwd_data1  (fwd_data1)
`endif
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [2:0]  ma;
    logic [15:0] md;
    logic        wb;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        ar;
    logic        mr;
    logic [7:0]  pm;
  } vec_t;

  function automatic vec_t mk(logic rst, logic av, logic [2:0] aa, logic [15:0] ad,
                              logic mv, logic [2:0] ma, logic [15:0] md,
                              logic wb, logic [2:0] wa, logic [15:0] wd,
                              logic ar, logic mr, logic [7:0] pm);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.wb = wb; v.wa = wa; v.wd = wd; v.ar = ar; v.mr = mr; v.pm = pm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  vec_t           vecs[$];
  logic [18:0]    qa[$];
  logic [18:0]    qm[$];
  logic [18:0]    exp_w;
  int unsigned    na, nm, widx, wins;

  // Stream scoreboard: grants alternate MEM, ALU, MEM, ... from the first write.
  task automatic take_write();
    if (widx[0] == 1'b0) begin
      if (qm.size() == 0) exp_w = 19'h7FFFF; else exp_w = qm.pop_front();
    end else begin
      if (qa.size() == 0) exp_w = 19'h7FFFF; else exp_w = qa.pop_front();
    end
    chk($sformatf("stream_write%0d", widx), {45'd0, write_addr, write_data}, {45'd0, exp_w});
    widx++;
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
`ifdef WB_FWD_EN
    fwd_addr0 = '0; fwd_addr1 = '0;
`endif

    //        rst av aa  ad        mv ma  md        wb wa  wd        ar mr pm
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 8'h08));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 16'h1234, 1, 1, 8'h08));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 3, 16'h1234, 1, 1, 8'h00));
    vecs.push_back(mk(1, 1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 3, 16'h1234, 1, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 3, 16'h1234, 0, 1, 8'h06));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 16'h5555, 1, 1, 8'h06));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 16'h0BEE, 1, 1, 16'hAAAA, 1, 1, 8'h02));
    vecs.push_back(mk(1, 1, 5, 16'h1111, 1, 5, 16'h2222, 0, 1, 16'hAAAA, 1, 1, 8'h01));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0BEE, 0, 1, 8'h21));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 16'h2222, 1, 1, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 16'h1111, 1, 1, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 5, 16'h1111, 1, 1, 8'h00));
    vecs.push_back(mk(1, 1, 6, 16'h6666, 1, 7, 16'h7777, 0, 5, 16'h1111, 1, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 5, 16'h1111, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 8'h00));

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
      #1;
      chk($sformatf("vec%0d", i),
          {34'd0, write_back, write_addr, write_data, alu_ready, mem_ready, pend_mask},
          {34'd0, vecs[i].wb, vecs[i].wa, vecs[i].wd, vecs[i].ar, vecs[i].mr, vecs[i].pm});
    end

    // Both sources streaming to disjoint registers for 20 cycles.
    na = 0; nm = 0; widx = 0; wins = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_addr = 3'(na % 4);     alu_data = 16'hA000 + 16'(na);
      mem_valid = 1'b1; mem_addr = 3'(4 + nm % 4); mem_data = 16'hB000 + 16'(nm);
      #1;
      chk($sformatf("stream_ready%0d", i), {62'd0, alu_ready, mem_ready},
          {62'd0, (i == 0) || (i % 2 == 0), (i == 0) || (i % 2 == 1)});
      if (alu_ready) begin qa.push_back({alu_addr, alu_data}); na++; end
      if (mem_ready) begin qm.push_back({mem_addr, mem_data}); nm++; end
      @(posedge clk); #1;
      chk($sformatf("stream_wb%0d", i), {63'd0, write_back}, {63'd0, i != 0});
      if (write_back) begin take_write(); wins++; end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      alu_valid = 1'b0; mem_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("drain_wb%0d", j), {63'd0, write_back}, {63'd0, j < 2});
      if (write_back) begin
        take_write();
        if (j == 0) wins++;
      end
    end
    chk("stream_alu_accepts", 64'(na), 64'd10);
    chk("stream_mem_accepts", 64'(nm), 64'd11);
    chk("stream_writes_in_window", 64'(wins), 64'd20);
    chk("stream_total_writes", 64'(widx), 64'd21);
    chk("stream_leftover", 64'(qa.size() + qm.size()), 64'd0);

`ifdef WB_FWD_EN
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 16'h0F0F;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    fwd_addr0 = 3'd4; fwd_addr1 = 3'd6;
    #1;
    chk("fwd_hold_hit",  {47'd0, fwd_hit0, fwd_data0}, {47'd0, 1'b1, 16'h0F0F});
    chk("fwd_miss",      {63'd0, fwd_hit1}, 64'd0);
    @(posedge clk); #1;
    chk("fwd_out_hit",   {47'd0, fwd_hit0, fwd_data0}, {47'd0, 1'b1, 16'h0F0F});
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h2222;
    @(posedge clk); #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    fwd_addr0 = 3'd5;
    #1;
    chk("fwd_youngest",  {47'd0, fwd_hit0, fwd_data0}, {47'd0, 1'b1, 16'h1111});
    @(posedge clk); #1;
    chk("fwd_hold_over_out", {47'd0, fwd_hit0, fwd_data0}, {47'd0, 1'b1, 16'h1111});
    repeat (3) @(posedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
